local_store: RTL and testbench

LOCAL_STORE -- requirements
Module: local_store

---
 rtl/local_store.sv | 195 +++++++++++++++++++
 tb/tb_local_store.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_store.sv
// -----------------------------------------------------------------------------
// local_store
//
// Quadword-organised local store for the odd pipe. Holds 2**(LS_ADDR_W-4)
// lines of DATA_W bits. After reset the store sweeps every line to zero, one
// line per cycle (CLEAR), and then accepts requests (READY) until the next
// reset. Requests seen during the sweep are discarded and reported with a
// one-cycle ls_req_dropped pulse.
//
// Reads are fully pipelined. A read sampled at edge N appears on ls_data_out
// with ls_rd_valid high after edge N+RD_LATENCY, for one cycle. The line is
// captured at issue, so later writes never disturb a read already in flight.
//
// Parameters
//   LS_ADDR_W  : byte-address width (low 4 bits ignored, quadword aligned)
//   DATA_W     : quadword width in bits
//   RD_LATENCY : read issue-to-data cycles, 1..8
//
// Ports
//   clock          : sole clock, rising edge
//   reset          : asynchronous, active-low reset
//   ls_address     : byte address, bit 0 is the MSB
//   ls_wrt_en      : write request this cycle
//   ls_rd_en       : read request this cycle
//   ls_data_in     : store quadword
//   ls_data_out    : load quadword, holds its value between reads
//   ls_rd_valid    : ls_data_out carries a completed read this cycle
//   ls_ready       : store accepts requests (sweep finished)
//   ls_req_dropped : one-cycle pulse, a request was discarded during CLEAR
// -----------------------------------------------------------------------------
module local_store #(
   parameter int LS_ADDR_W  = 15,
   parameter int DATA_W     = 128,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [0:LS_ADDR_W-1]  ls_address,
   input  logic                  ls_wrt_en,
   input  logic                  ls_rd_en,
   input  logic [0:DATA_W-1]     ls_data_in,
   output logic [0:DATA_W-1]     ls_data_out,
   output logic                  ls_rd_valid,
   output logic                  ls_ready,
   output logic                  ls_req_dropped
);

   localparam int IDX_W     = LS_ADDR_W - 4;
   localparam int NUM_LINES = 1 << IDX_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              drop_q, drop_d;

   // Stage 0 of the read path: registered array read plus bypass capture.
   logic              rd_v0_q, rd_v0_d;
   logic              byp_q, byp_d;
   logic [0:DATA_W-1] byp_data_q;
   logic [0:DATA_W-1] mem_rd_q;
   logic [0:DATA_W-1] stage0_data;

   // Delay stages; the last one is the output register.
   logic [RD_LATENCY-1:0] pipe_v_q, pipe_v_d;
   logic [0:DATA_W-1]     pipe_data_q [RD_LATENCY];
   logic [0:DATA_W-1]     pipe_data_d [RD_LATENCY];

   // Single write port shared by the clear sweep and normal stores.
   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [0:DATA_W-1] mem_wdata;
   logic              rd_issue;

   logic [0:DATA_W-1] mem [NUM_LINES];

   logic [IDX_W-1:0]  line_idx;
   logic              unused_low_bits;

   // Quadword alignment: the byte-offset nibble is dropped.
   assign line_idx        = ls_address[0:LS_ADDR_W-5];
   assign unused_low_bits = ^ls_address[LS_ADDR_W-4:LS_ADDR_W-1];

   // --------------------------------------------------------------------------
   // Control FSM: next state, clear counter, write port and read issue.
   // --------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      drop_d    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = clr_cnt_q;
      mem_wdata = '0;
      rd_issue  = 1'b0;
      byp_d     = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            mem_we    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            drop_d    = ls_rd_en | ls_wrt_en;
            if (clr_cnt_q == '1) begin
               state_d = ST_READY;
            end
         end
         ST_READY: begin
            mem_we    = ls_wrt_en;
            mem_waddr = line_idx;
            mem_wdata = ls_data_in;
            rd_issue  = ls_rd_en;
            // Read and write share one address, so a simultaneous pair always
            // targets the same line and the read must see the new data.
            byp_d     = ls_rd_en & ls_wrt_en;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   assign rd_v0_d = rd_issue;

   // --------------------------------------------------------------------------
   // Storage array with registered read (read-before-write; the bypass
   // register supplies write-first behaviour on a same-cycle collision).
   // --------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
      if (rd_issue) begin
         mem_rd_q   <= mem[line_idx];
         byp_data_q <= ls_data_in;
      end
   end

   assign stage0_data = byp_q ? byp_data_q : mem_rd_q;

   // --------------------------------------------------------------------------
   // Read delay pipeline. Data registers load only when a valid read passes,
   // so the last stage holds the previous result between reads.
   // --------------------------------------------------------------------------
   always_comb begin
      pipe_v_d = '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
         pipe_data_d[i] = pipe_data_q[i];
      end
      pipe_v_d[0] = rd_v0_q;
      if (rd_v0_q) begin
         pipe_data_d[0] = stage0_data;
      end
      for (int i = 1; i < RD_LATENCY; i++) begin
         pipe_v_d[i] = pipe_v_q[i-1];
         if (pipe_v_q[i-1]) begin
            pipe_data_d[i] = pipe_data_q[i-1];
         end
      end
   end

   // --------------------------------------------------------------------------
   // State registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         drop_q    <= 1'b0;
         rd_v0_q   <= 1'b0;
         byp_q     <= 1'b0;
         pipe_v_q  <= '0;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_data_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         drop_q    <= drop_d;
         rd_v0_q   <= rd_v0_d;
         byp_q     <= byp_d;
         pipe_v_q  <= pipe_v_d;
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_data_q[i] <= pipe_data_d[i];
         end
      end
   end

   assign ls_data_out    = pipe_data_q[RD_LATENCY-1];
   assign ls_rd_valid    = pipe_v_q[RD_LATENCY-1];
   assign ls_ready       = (state_q == ST_READY);
   assign ls_req_dropped = drop_q;

endmodule

// File: tb/tb_local_store.sv
// -----------------------------------------------------------------------------
// tb_local_store
//
// Self-checking bench for local_store. A reference model (line array plus a
// queue of pending read results with their due cycle) predicts every read
// return; directed scenarios and a randomized stream are compared against it.
// -----------------------------------------------------------------------------
module tb_local_store;

   localparam int AW    = 15;
   localparam int DW    = 128;
   localparam int L     = 2;
   localparam int LINES = 1 << (AW - 4);

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic [AW-1:0] ls_address = '0;
   logic          ls_wrt_en = 1'b0;
   logic          ls_rd_en = 1'b0;
   logic [DW-1:0] ls_data_in = '0;
   logic [DW-1:0] ls_data_out;
   logic          ls_rd_valid;
   logic          ls_ready;
   logic          ls_req_dropped;

   local_store #(
      .LS_ADDR_W  (AW),
      .DATA_W     (DW),
      .RD_LATENCY (L)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .ls_address     (ls_address),
      .ls_wrt_en      (ls_wrt_en),
      .ls_rd_en       (ls_rd_en),
      .ls_data_in     (ls_data_in),
      .ls_data_out    (ls_data_out),
      .ls_rd_valid    (ls_rd_valid),
      .ls_ready       (ls_ready),
      .ls_req_dropped (ls_req_dropped)
   );

   always #5 clock = ~clock;

   int pass_cnt      = 0;
   int total_cnt     = 0;
   int cyc           = 0;
   int since_release = 0;
   bit model_ready   = 1'b0;

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } rd_t;

   logic [DW-1:0] model [LINES];
   rd_t           pend [$];
   logic          exp_v   = 1'b0;
   logic [DW-1:0] exp_out = '0;

   // Drive one cycle of requests, advance past the edge and update the model.
   task automatic tick(input logic rd, input logic wr,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
      int  idx;
      rd_t e;
      ls_rd_en   = rd;
      ls_wrt_en  = wr;
      ls_address = a;
      ls_data_in = d;
      @(posedge clock);
      #1;
      cyc++;
      since_release++;
      if (rd || wr) begin
         $display("cyc %0d rd=%b wr=%b addr=%h wdata=%h ready=%b", cyc, rd, wr, a, d, ls_ready);
      end
      idx = int'(a[AW-1:4]);
      if (model_ready) begin
         if (rd) begin
            e.due  = cyc + L;
            e.data = wr ? d : model[idx];
            pend.push_back(e);
         end
         if (wr) begin
            model[idx] = d;
         end
      end
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         e       = pend.pop_front();
         exp_v   = 1'b1;
         exp_out = e.data;
      end
      ls_rd_en  = 1'b0;
      ls_wrt_en = 1'b0;
   endtask

   task automatic idle();
      tick(1'b0, 1'b0, '0, '0);
   endtask

   // After a completed sweep every line is zero and nothing is in flight.
   task automatic model_zero();
      for (int i = 0; i < LINES; i++) begin
         model[i] = '0;
      end
      pend.delete();
      exp_v       = 1'b0;
      exp_out     = '0;
      model_ready = 1'b1;
   endtask

   task automatic test_reset();
      #3 reset = 1'b0;
      #1;
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", ls_rd_valid); else pass_cnt++;
      total_cnt++;
      if (ls_data_out !== '0) $display("FAIL reset_data_out: got %h want 0", ls_data_out); else pass_cnt++;
      total_cnt++;
      if (ls_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", ls_ready); else pass_cnt++;
      total_cnt++;
      if (ls_req_dropped !== 1'b0) $display("FAIL reset_dropped: got %b want 0", ls_req_dropped); else pass_cnt++;
      repeat (3) idle();
      total_cnt++;
      if (ls_ready !== 1'b0) $display("FAIL reset_hold_ready: got %b want 0", ls_ready); else pass_cnt++;
      reset         = 1'b1;
      since_release = 0;
   endtask

   task automatic test_clear_drop();
      idle();
      idle();
      tick(1'b0, 1'b1, 15'h0010, 128'd5);
      total_cnt++;
      if (ls_req_dropped !== 1'b1) $display("FAIL clear_drop_wr: got %b want 1", ls_req_dropped); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_req_dropped !== 1'b0) $display("FAIL clear_drop_pulse_end: got %b want 0", ls_req_dropped); else pass_cnt++;
      tick(1'b1, 1'b0, 15'h7FF0, '0);
      total_cnt++;
      if (ls_req_dropped !== 1'b1) $display("FAIL clear_drop_rd: got %b want 1", ls_req_dropped); else pass_cnt++;
      for (int i = 0; i < L + 1; i++) begin
         idle();
         total_cnt++;
         if (ls_rd_valid !== 1'b0) $display("FAIL clear_no_read: got %b want 0", ls_rd_valid); else pass_cnt++;
      end
      total_cnt++;
      if (ls_ready !== 1'b0) $display("FAIL clear_ready_low: got %b want 0", ls_ready); else pass_cnt++;
   endtask

   task automatic test_clear_sweep();
      int guard = 0;
      while (!ls_ready && guard < 5000) begin
         idle();
         guard++;
      end
      total_cnt++;
      if (ls_ready !== 1'b1) $display("FAIL sweep_timeout: got ready=%b want 1", ls_ready); else pass_cnt++;
      total_cnt++;
      if (since_release != LINES) $display("FAIL sweep_length: got %0d cycles want %0d", since_release, LINES); else pass_cnt++;
      model_zero();
   endtask

   task automatic test_sweep_zero();
      tick(1'b1, 1'b0, 15'h7FF0, '0);
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL zero_latency_early: got %b want 0", ls_rd_valid); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL zero_latency_mid: got %b want 0", ls_rd_valid); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1) $display("FAIL zero_valid: got %b want 1", ls_rd_valid); else pass_cnt++;
      total_cnt++;
      if (ls_data_out !== '0) $display("FAIL zero_data_7ff0: got %h want 0", ls_data_out); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL zero_single_pulse: got %b want 0", ls_rd_valid); else pass_cnt++;
      // The write dropped during CLEAR must not have reached line 1.
      tick(1'b1, 1'b0, 15'h0010, '0);
      idle();
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1 || ls_data_out !== '0) $display("FAIL dropped_write_absent: got v=%b d=%h want v=1 d=0", ls_rd_valid, ls_data_out); else pass_cnt++;
   endtask

   task automatic test_align();
      tick(1'b0, 1'b1, 15'h0020, 128'd20);
      tick(1'b1, 1'b0, 15'h002F, '0);
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL align_early: got %b want 0", ls_rd_valid); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1 || ls_data_out !== 128'd20) $display("FAIL align_data: got v=%b d=%h want v=1 d=%h", ls_rd_valid, ls_data_out, 128'd20); else pass_cnt++;
   endtask

   task automatic test_bypass();
      tick(1'b1, 1'b1, 15'h0030, 128'd77);
      idle();
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1 || ls_data_out !== 128'd77) $display("FAIL bypass_same_cycle: got v=%b d=%h want v=1 d=%h", ls_rd_valid, ls_data_out, 128'd77); else pass_cnt++;
      tick(1'b1, 1'b0, 15'h0030, '0);
      tick(1'b0, 1'b1, 15'h0030, 128'd99);
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1 || ls_data_out !== 128'd77) $display("FAIL inflight_capture: got v=%b d=%h want v=1 d=%h", ls_rd_valid, ls_data_out, 128'd77); else pass_cnt++;
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b0 || ls_data_out !== 128'd77) $display("FAIL hold_after_read: got v=%b d=%h want v=0 d=%h", ls_rd_valid, ls_data_out, 128'd77); else pass_cnt++;
      tick(1'b1, 1'b0, 15'h0030, '0);
      idle();
      idle();
      total_cnt++;
      if (ls_rd_valid !== 1'b1 || ls_data_out !== 128'd99) $display("FAIL later_write_landed: got v=%b d=%h want v=1 d=%h", ls_rd_valid, ls_data_out, 128'd99); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] addrs [3];
      logic [DW-1:0] vals  [3];
      addrs[0] = 15'h0000; addrs[1] = 15'h0010; addrs[2] = 15'h0020;
      vals[0]  = 128'd1;   vals[1]  = 128'd2;   vals[2]  = 128'd3;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, addrs[i], vals[i]);
      end
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 1'b0, addrs[i], '0);
      end
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (ls_rd_valid !== 1'b1 || ls_data_out !== vals[i]) $display("FAIL b2b_read%0d: got v=%b d=%h want v=1 d=%h", i, ls_rd_valid, ls_data_out, vals[i]); else pass_cnt++;
         idle();
      end
      total_cnt++;
      if (ls_rd_valid !== 1'b0 || ls_data_out !== 128'd3) $display("FAIL b2b_tail: got v=%b d=%h want v=0 d=%h", ls_rd_valid, ls_data_out, 128'd3); else pass_cnt++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 600 + L + 1; i++) begin
         logic          rd;
         logic          wr;
         logic [AW-1:0] a;
         logic [DW-1:0] d;
         rd = (i < 600) && (($urandom % 3) != 0);
         wr = (i < 600) && (($urandom % 2) == 1);
         a  = AW'((($urandom % 8) << 4) | ($urandom % 16));
         if (($urandom % 8) == 0) a = AW'($urandom);
         d  = {$urandom, $urandom, $urandom, $urandom};
         tick(rd, wr, a, d);
         total_cnt++;
         if (ls_rd_valid !== exp_v) $display("FAIL rand_valid cyc %0d: got %b want %b", cyc, ls_rd_valid, exp_v); else pass_cnt++;
         total_cnt++;
         if (ls_data_out !== exp_out) $display("FAIL rand_data cyc %0d: got %h want %h", cyc, ls_data_out, exp_out); else pass_cnt++;
         total_cnt++;
         if (ls_req_dropped !== 1'b0) $display("FAIL rand_dropped cyc %0d: got %b want 0", cyc, ls_req_dropped); else pass_cnt++;
      end
   endtask

   task automatic test_reset_inflight();
      int guard = 0;
      tick(1'b0, 1'b1, 15'h0000, 128'hDEAD);
      tick(1'b0, 1'b1, 15'h0050, 128'hBEEF);
      tick(1'b1, 1'b0, 15'h0000, '0);
      tick(1'b1, 1'b0, 15'h0050, '0);
      reset       = 1'b0;
      model_ready = 1'b0;
      pend.delete();
      exp_v       = 1'b0;
      #1;
      total_cnt++;
      if (ls_rd_valid !== 1'b0) $display("FAIL rst_inflight_valid: got %b want 0", ls_rd_valid); else pass_cnt++;
      total_cnt++;
      if (ls_data_out !== '0) $display("FAIL rst_inflight_data: got %h want 0", ls_data_out); else pass_cnt++;
      total_cnt++;
      if (ls_ready !== 1'b0) $display("FAIL rst_inflight_ready: got %b want 0", ls_ready); else pass_cnt++;
      for (int i = 0; i < L + 1; i++) begin
         idle();
         total_cnt++;
         if (ls_rd_valid !== 1'b0) $display("FAIL rst_inflight_discard: got %b want 0", ls_rd_valid); else pass_cnt++;
      end
      reset         = 1'b1;
      since_release = 0;
      while (!ls_ready && guard < 5000) begin
         idle();
         guard++;
      end
      total_cnt++;
      if (ls_ready !== 1'b1) $display("FAIL resweep_timeout: got ready=%b want 1", ls_ready); else pass_cnt++;
      total_cnt++;
      if (since_release != LINES) $display("FAIL resweep_length: got %0d cycles want %0d", since_release, LINES); else pass_cnt++;
      model_zero();
      tick(1'b1, 1'b0, 15'h0000, '0);
      tick(1'b1, 1'b0, 15'h0050, '0);
      for (int i = 0; i < 2; i++) begin
         idle();
         total_cnt++;
         if (ls_rd_valid !== exp_v || ls_data_out !== exp_out) $display("FAIL resweep_zeroed%0d: got v=%b d=%h want v=%b d=%h", i, ls_rd_valid, ls_data_out, exp_v, exp_out); else pass_cnt++;
      end
   endtask

   initial begin
      test_reset();
      test_clear_drop();
      test_clear_sweep();
      test_sweep_zero();
      test_align();
      test_bypass();
      test_back_to_back();
      test_random();
      test_reset_inflight();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
